z80fi_insn_recorder: RTL and testbench

//   Producer side of the z80fi formal interface. Tracks one instruction at a time through the core:

---
 rtl/z80fi_insn_recorder.sv | 169 ++++++++++++++++
 tb/tb_z80fi_insn_recorder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/z80fi_insn_recorder.sv
// z80fi_insn_recorder
//   Producer side of the z80fi formal interface. It follows one instruction at a
//   time through the core:
//     - captures A/F/IP when the instruction starts;
//     - collects the fetched opcode bytes;
//     - captures A/F/IP when the instruction retires.
//   On retirement it presents one complete record with a single-cycle
//   z80fi_valid pulse. The block only observes the core and never drives it.
//
// Ports
//   clk, reset          core clock; synchronous active-high reset
//   insn_start          pulse, first cycle of a new instruction
//   fetch_valid         fetch_byte belongs to the current instruction
//   fetch_byte          opcode/operand byte, in fetch order
//   insn_done           pulse, the current instruction retires this cycle
//   cur_a/cur_f/cur_ip  live A, F and IP taps
//   z80fi_valid         one-cycle pulse, the record outputs are complete
//   z80fi_insn          fetched bytes, first-fetched byte in [7:0], unfetched bytes zero
//   z80fi_insn_len      number of bytes fetched (1..MAX_LEN)
//   z80fi_reg_*_in      A/F/IP at insn_start
//   z80fi_reg_*_out     A/F/IP at insn_done
//   rec_overflow        sticky flag, an instruction fetched more than MAX_LEN bytes
//
// MAX_LEN must be in the range 1..7 because the length field is 3 bits wide.

module z80fi_insn_recorder #(
  parameter int MAX_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   insn_start,
  input  logic                   fetch_valid,
  input  logic [7:0]             fetch_byte,
  input  logic                   insn_done,
  input  logic [7:0]             cur_a,
  input  logic [7:0]             cur_f,
  input  logic [15:0]            cur_ip,
  output logic                   z80fi_valid,
  output logic [8*MAX_LEN-1:0]   z80fi_insn,
  output logic [2:0]             z80fi_insn_len,
  output logic [7:0]             z80fi_reg_a_in,
  output logic [7:0]             z80fi_reg_f_in,
  output logic [15:0]            z80fi_reg_ip_in,
  output logic [7:0]             z80fi_reg_a_out,
  output logic [7:0]             z80fi_reg_f_out,
  output logic [15:0]            z80fi_reg_ip_out,
  output logic                   rec_overflow
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             count_reg, count_next;
  logic [8*MAX_LEN-1:0]   buf_reg, buf_next, buf_merged;
  logic [7:0]             a_in_reg, f_in_reg;
  logic [15:0]            ip_in_reg;

  logic                   valid_reg;
  logic [8*MAX_LEN-1:0]   insn_reg;
  logic [2:0]             len_reg;
  logic [7:0]             rec_a_in_reg, rec_f_in_reg, rec_a_out_reg, rec_f_out_reg;
  logic [15:0]            rec_ip_in_reg, rec_ip_out_reg;
  logic                   overflow_reg;

  logic                   active, retire, fetch_cur, fetch_new, room;
  logic                   store_cur, overflow_hit, emit;
  logic [2:0]             count_merged;

  assign active = (state_reg == ACTIVE);
  assign retire = active && insn_done;

  // A byte belongs to the running instruction unless that instruction is
  // being aborted this cycle (start without done). In the abort case the
  // byte goes to the freshly started instruction.
  assign fetch_cur = fetch_valid && active && (!insn_start || insn_done);
  assign fetch_new = fetch_valid && insn_start && !fetch_cur;

  assign room         = (count_reg < 3'(MAX_LEN));
  assign store_cur    = fetch_cur && room;
  assign overflow_hit = fetch_cur && !room;
  assign count_merged = count_reg + {2'b00, store_cur};

  // A retire with no bytes at all is malformed and produces no record.
  assign emit = retire && (count_merged != 3'd0);

  // The buffer as it looks with this cycle's byte included. A retire uses
  // this view so that a byte fetched in the retire cycle is recorded.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_merge
    assign buf_merged[8*gi +: 8] = (store_cur && (count_reg == 3'(gi)))
                                   ? fetch_byte : buf_reg[8*gi +: 8];
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    buf_next   = buf_reg;
    if (insn_start) begin
      // Start a new capture. Any retiring instruction has already taken its
      // record from buf_merged in this same cycle.
      state_next    = ACTIVE;
      buf_next      = '0;
      buf_next[7:0] = fetch_new ? fetch_byte : 8'h00;
      count_next    = fetch_new ? 3'd1 : 3'd0;
    end else if (retire) begin
      state_next = IDLE;
      buf_next   = '0;
      count_next = 3'd0;
    end else if (active) begin
      buf_next   = buf_merged;
      count_next = count_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= 3'd0;
      buf_reg        <= '0;
      a_in_reg       <= 8'h00;
      f_in_reg       <= 8'h00;
      ip_in_reg      <= 16'h0000;
      valid_reg      <= 1'b0;
      insn_reg       <= '0;
      len_reg        <= 3'd0;
      rec_a_in_reg   <= 8'h00;
      rec_f_in_reg   <= 8'h00;
      rec_ip_in_reg  <= 16'h0000;
      rec_a_out_reg  <= 8'h00;
      rec_f_out_reg  <= 8'h00;
      rec_ip_out_reg <= 16'h0000;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      buf_reg      <= buf_next;
      valid_reg    <= emit;
      overflow_reg <= overflow_reg | overflow_hit;
      if (insn_start) begin
        a_in_reg  <= cur_a;
        f_in_reg  <= cur_f;
        ip_in_reg <= cur_ip;
      end
      // The record registers change only on retire and hold their value
      // until the next retire.
      if (emit) begin
        insn_reg       <= buf_merged;
        len_reg        <= count_merged;
        rec_a_in_reg   <= a_in_reg;
        rec_f_in_reg   <= f_in_reg;
        rec_ip_in_reg  <= ip_in_reg;
        rec_a_out_reg  <= cur_a;
        rec_f_out_reg  <= cur_f;
        rec_ip_out_reg <= cur_ip;
      end
    end
  end

  assign z80fi_valid      = valid_reg;
  assign z80fi_insn       = insn_reg;
  assign z80fi_insn_len   = len_reg;
  assign z80fi_reg_a_in   = rec_a_in_reg;
  assign z80fi_reg_f_in   = rec_f_in_reg;
  assign z80fi_reg_ip_in  = rec_ip_in_reg;
  assign z80fi_reg_a_out  = rec_a_out_reg;
  assign z80fi_reg_f_out  = rec_f_out_reg;
  assign z80fi_reg_ip_out = rec_ip_out_reg;
  assign rec_overflow     = overflow_reg;

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Directed testbench for z80fi_insn_recorder.
//   - Expected records are pushed to a scoreboard queue when insn_done is
//     driven.
//   - A record is popped and compared whenever z80fi_valid is seen.
//   - A valid pulse that arrives with an empty queue counts as a miscompare.

module tb_z80fi_insn_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic        insn_start, fetch_valid, insn_done;
  logic [7:0]  fetch_byte, cur_a, cur_f;
  logic [15:0] cur_ip;
  logic        z80fi_valid, rec_overflow;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [7:0]  z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_a_out, z80fi_reg_f_out;
  logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out;

  always #5 clk = ~clk;

  z80fi_insn_recorder #(.MAX_LEN(4)) dut (
    .clk(clk), .reset(reset), .insn_start(insn_start), .fetch_valid(fetch_valid),
    .fetch_byte(fetch_byte), .insn_done(insn_done), .cur_a(cur_a), .cur_f(cur_f),
    .cur_ip(cur_ip), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
    .z80fi_insn_len(z80fi_insn_len), .z80fi_reg_a_in(z80fi_reg_a_in),
    .z80fi_reg_f_in(z80fi_reg_f_in), .z80fi_reg_ip_in(z80fi_reg_ip_in),
    .z80fi_reg_a_out(z80fi_reg_a_out), .z80fi_reg_f_out(z80fi_reg_f_out),
    .z80fi_reg_ip_out(z80fi_reg_ip_out), .rec_overflow(rec_overflow)
  );

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  len;
    logic [7:0]  a_in, f_in, a_out, f_out;
    logic [15:0] ip_in, ip_out;
  } rec_t;

  rec_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   records     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] insn, input logic [2:0] len,
                      input logic [7:0] a_in, input logic [7:0] f_in, input logic [15:0] ip_in,
                      input logic [7:0] a_out, input logic [7:0] f_out, input logic [15:0] ip_out);
    rec_t r;
    r.insn = insn; r.len = len; r.a_in = a_in; r.f_in = f_in; r.ip_in = ip_in;
    r.a_out = a_out; r.f_out = f_out; r.ip_out = ip_out;
    sb.push_back(r);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    rec_t r;
    @(posedge clk);
    #1;
    if (z80fi_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'd0, z80fi_valid}, 32'd0);
      end else begin
        r = sb.pop_front();
        records++;
        $display("record %0d: insn=%08h len=%0d a_in=%02h f_in=%02h ip_in=%04h a_out=%02h f_out=%02h ip_out=%04h",
                 records, z80fi_insn, z80fi_insn_len, z80fi_reg_a_in, z80fi_reg_f_in,
                 z80fi_reg_ip_in, z80fi_reg_a_out, z80fi_reg_f_out, z80fi_reg_ip_out);
        chk("insn",   z80fi_insn, r.insn);
        chk("len",    {29'd0, z80fi_insn_len}, {29'd0, r.len});
        chk("a_in",   {24'd0, z80fi_reg_a_in}, {24'd0, r.a_in});
        chk("f_in",   {24'd0, z80fi_reg_f_in}, {24'd0, r.f_in});
        chk("ip_in",  {16'd0, z80fi_reg_ip_in}, {16'd0, r.ip_in});
        chk("a_out",  {24'd0, z80fi_reg_a_out}, {24'd0, r.a_out});
        chk("f_out",  {24'd0, z80fi_reg_f_out}, {24'd0, r.f_out});
        chk("ip_out", {16'd0, z80fi_reg_ip_out}, {16'd0, r.ip_out});
      end
    end
  endtask

  // Drive one cycle of stimulus; the pulse inputs return low afterwards.
  task automatic cyc(input logic st, input logic fv, input logic [7:0] fb, input logic dn,
                     input logic [7:0] a, input logic [7:0] f, input logic [15:0] ip);
    insn_start = st; fetch_valid = fv; fetch_byte = fb; insn_done = dn;
    cur_a = a; cur_f = f; cur_ip = ip;
    tick();
    insn_start = 1'b0; fetch_valid = 1'b0; insn_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, z80fi_valid}, 32'd0);
    chk({tag, "_insn"},  z80fi_insn, 32'd0);
    chk({tag, "_len"},   {29'd0, z80fi_insn_len}, 32'd0);
    chk({tag, "_regs"},  {z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_a_out, z80fi_reg_f_out}, 32'd0);
    chk({tag, "_ips"},   {z80fi_reg_ip_in, z80fi_reg_ip_out}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, rec_overflow}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; insn_start = 1'b0; fetch_valid = 1'b0; insn_done = 1'b0;
    fetch_byte = 8'h00; cur_a = 8'h00; cur_f = 8'h00; cur_ip = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_all_zero("reset");

    // NEG: ED 44
    cyc(1, 0, 8'h00, 0, 8'h01, 8'h00, 16'h0100);
    cyc(0, 1, 8'hED, 0, 8'h55, 8'h55, 16'h5555);
    cyc(0, 1, 8'h44, 0, 8'h55, 8'h55, 16'h5555);
    push(32'h0000_44ED, 3'd2, 8'h01, 8'h00, 16'h0100, 8'hFF, 8'hBB, 16'h0102);
    cyc(0, 0, 8'h00, 1, 8'hFF, 8'hBB, 16'h0102);
    chk("neg_seen", records, 1);
    tick();

    // NOP: start and fetch in the same cycle
    cyc(1, 1, 8'h00, 0, 8'h10, 8'h20, 16'h0200);
    push(32'h0000_0000, 3'd1, 8'h10, 8'h20, 16'h0200, 8'h11, 8'h21, 16'h0201);
    cyc(0, 0, 8'h00, 1, 8'h11, 8'h21, 16'h0201);
    chk("nop_seen", records, 2);
    tick();

    // Overflow: five bytes, the fifth is dropped
    chk("ovf_before", {31'd0, rec_overflow}, 32'd0);
    cyc(1, 0, 8'h00, 0, 8'h30, 8'h31, 16'h0300);
    cyc(0, 1, 8'hDD, 0, 8'h30, 8'h31, 16'h0300);
    cyc(0, 1, 8'hCB, 0, 8'h30, 8'h31, 16'h0300);
    cyc(0, 1, 8'h05, 0, 8'h30, 8'h31, 16'h0300);
    cyc(0, 1, 8'h06, 0, 8'h30, 8'h31, 16'h0300);
    cyc(0, 1, 8'h07, 0, 8'h30, 8'h31, 16'h0300);
    push(32'h0605_CBDD, 3'd4, 8'h30, 8'h31, 16'h0300, 8'h32, 8'h33, 16'h0304);
    cyc(0, 0, 8'h00, 1, 8'h32, 8'h33, 16'h0304);
    chk("ovf_after", {31'd0, rec_overflow}, 32'd1);
    tick();

    // Abort: the first instruction is abandoned, only the restart retires
    cyc(1, 0, 8'h00, 0, 8'h40, 8'h41, 16'h0400);
    cyc(0, 1, 8'hED, 0, 8'h40, 8'h41, 16'h0400);
    cyc(1, 0, 8'h00, 0, 8'h22, 8'h23, 16'h0402);
    cyc(0, 1, 8'h3E, 0, 8'h22, 8'h23, 16'h0402);
    cyc(0, 1, 8'h10, 0, 8'h22, 8'h23, 16'h0402);
    push(32'h0000_103E, 3'd2, 8'h22, 8'h23, 16'h0402, 8'h10, 8'h24, 16'h0404);
    cyc(0, 0, 8'h00, 1, 8'h10, 8'h24, 16'h0404);
    chk("abort_seen", records, 4);
    tick();

    // Chained: done+start in one cycle; that cycle's byte belongs to the
    // retiring instruction
    cyc(1, 1, 8'h3C, 0, 8'h50, 8'h51, 16'h0500);
    push(32'h0000_003C, 3'd2, 8'h50, 8'h51, 16'h0500, 8'h60, 8'h61, 16'h0502);
    cyc(1, 1, 8'h00, 1, 8'h60, 8'h61, 16'h0502);
    cyc(0, 1, 8'h04, 0, 8'h66, 8'h66, 16'h6666);
    push(32'h0000_0004, 3'd1, 8'h60, 8'h61, 16'h0502, 8'h70, 8'h71, 16'h0503);
    cyc(0, 0, 8'h00, 1, 8'h70, 8'h71, 16'h0503);
    chk("chain_seen", records, 6);
    chk("ovf_sticky", {31'd0, rec_overflow}, 32'd1);

    // The record holds after valid has dropped
    cyc(0, 1, 8'hAB, 1, 8'h99, 8'h99, 16'h9999);  // IDLE: ignored
    tick();
    chk("hold_insn", z80fi_insn, 32'h0000_0004);
    chk("hold_a_out", {24'd0, z80fi_reg_a_out}, 32'h70);

    // Malformed: a done with no bytes produces no record
    cyc(1, 0, 8'h00, 0, 8'h80, 8'h81, 16'h0800);
    cyc(0, 0, 8'h00, 1, 8'h82, 8'h83, 16'h0801);
    tick();
    chk("malformed_none", records, 6);

    // Reset mid-instruction, then done: nothing is emitted and all outputs are 0
    cyc(1, 0, 8'h00, 0, 8'h90, 8'h91, 16'h0900);
    cyc(0, 1, 8'hAA, 0, 8'h90, 8'h91, 16'h0900);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc(0, 0, 8'h00, 1, 8'h92, 8'h93, 16'h0901);
    tick();
    chk_all_zero("midreset");
    chk("records_total", records, 6);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
